wb_dbg_master: RTL
==================

// Module: wb_dbg_master
// PURPOSE
//  Wishbone bus master driven by a UART byte stream; host debug/loader access to the SoC.
//  Decodes serial commands from the UART core's byte interface, runs single 32-bit Wishbone
//  read/write cycles and returns result bytes. Attaches to a spare conbus master port (m2).
// PARAMETERS
//  TIMEOUT   256    cycles cyc/stb may stay high without ack before the cycle aborts (>=2)
//  CMD_WR    8'h01  command byte: write word
//  CMD_RD    8'h02  command byte: read word
// PORTS
//  clk        in   1   system clock, single domain
//  rst        in   1   reset; asynchronous, active-high
//  rx_data    in   8   received byte from UART core
//  rx_stb     in   1   one-cycle pulse: rx_data valid; no backpressure
//  tx_data    out  8   byte to transmit
//  tx_wr      out  1   one-cycle pulse: load tx_data into UART core
//  tx_busy    in   1   UART transmitter busy
//  wb_adr_o   out  32  Wishbone address
//  wb_dat_o   out  32  Wishbone write data
//  wb_dat_i   in   32  Wishbone read data
//  wb_sel_o   out  4   byte selects, always 4'hF
//  wb_we_o    out  1   write enable
//  wb_cyc_o   out  1   cycle
//  wb_stb_o   out  1   strobe
//  wb_ack_i   in   1   acknowledge
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except wb_sel_o=4'hF; state IDLE; counters and shift regs cleared.
//  Frame: CMD, ADDR[31:24..7:0] (4 bytes MSB first), then for WR DATA 4 bytes MSB first.
//  Responses: WR ok -> 8'hAA; RD ok -> 4 data bytes MSB first; timeout -> single 8'hEE.
//  FSM: IDLE -> (rx_stb & CMD_WR/CMD_RD) ADDR; any other byte ignored, stay IDLE.
//   ADDR: shift 4 bytes (2-bit counter); after 4th: WR -> DATA, RD -> BUS.
//   DATA: shift 4 bytes; after 4th -> BUS.
//   BUS: cyc=stb=1 from edge after last byte; we=1 for WR. Held until ack.
//    ack sampled high: latch wb_dat_i (RD), drop cyc/stb/we next edge -> RESP.
//    Timeout counter cleared on BUS entry, +1 per cycle; reaching TIMEOUT-1 with no ack
//    -> drop cyc/stb/we next edge, response = 8'hEE -> RESP. Ack on that same cycle wins.
//   RESP: issue tx_wr only when tx_busy=0 and tx_wr was 0 last cycle (covers UART busy
//    latency); 1 byte (WR/timeout) or 4 bytes (RD); after last byte pulse -> IDLE.
//  rx_stb in BUS/RESP is dropped (no queueing). wb_adr_o/wb_dat_o stable for whole cycle.
//  One cycle at a time, never pipelined; at most one ack consumed per command.
//  Async rst mid-cycle: cyc/stb drop immediately; partial frame discarded.
// STRUCTURE
//  Shared include wb_dbg_defs.vh: CMD_WR/CMD_RD/RSP_OK(8'hAA)/RSP_ERR(8'hEE), state encodings.
//  Single flat module: FSM, 2-bit byte counter, 32-bit addr/data shift regs, timeout counter
//  ($clog2(TIMEOUT) bits), response byte mux. No sub-module.
// TESTING
//  WR: bytes 01 20 00 00 04 DE AD BE EF -> one cycle adr=0x20000004 dat=0xDEADBEEF we=1 sel=F; tx 0xAA.
//  RD: 02 00 00 01 00, slave acks 3 cycles later with 0x12345678 -> tx 12,34,56,78 in order.
//  Timeout: RD to an unacking slave, TIMEOUT=16 -> cyc drops after 16 cycles, tx 0xEE only.
//  Garbage: 0x7F, 0x00 then valid RD -> first two ignored, RD completes normally.
//  tx_busy held high 100 cycles in RESP -> no tx_wr until it falls, then one pulse per byte.
//  rst asserted while cyc=1 -> cyc/stb/tx_wr 0 at once; next full WR frame completes correctly.

Source files
------------

// File: rtl/wb_dbg_master_pkg.sv
// +----------------------------------------------------------------------+
// | wb_dbg_master_pkg: command/response codes, FSM states, byte helper   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package wb_dbg_master_pkg;

    localparam logic [7:0] C_CMD_WR  = 8'h01;
    localparam logic [7:0] C_CMD_RD  = 8'h02;
    localparam logic [7:0] C_RSP_OK  = 8'hAA;
    localparam logic [7:0] C_RSP_ERR = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Byte idx of a word, most significant byte first (idx 0 = [31:24]).
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_dbg_master_if.sv
// +----------------------------------------------------------------------+
// | wb_dbg_master_if: UART byte stream and Wishbone master signal bundle |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface wb_dbg_master_if;
    logic [7:0]  rx_data;
    logic        rx_stb;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    modport master (
        input  rx_data, rx_stb, tx_busy, wb_dat_i, wb_ack_i,
        output tx_data, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output rx_data, rx_stb, tx_busy, wb_dat_i, wb_ack_i,
        input  tx_data, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_dbg_master.sv
// +----------------------------------------------------------------------+
// | wb_dbg_master: UART-command driven single-word Wishbone master       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_dbg_master
    import wb_dbg_master_pkg::*;
#(
    parameter int         TIMEOUT = 256,
    parameter logic [7:0] CMD_WR  = C_CMD_WR,
    parameter logic [7:0] CMD_RD  = C_CMD_RD
) (
    input  wire logic         clk,
    input  wire logic         rst,
    wb_dbg_master_if.master   bus,
    output logic              busy
);

    localparam int              TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic           is_wr_q, is_wr_d;
    logic           err_q, err_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdat_q, wdat_d;
    logic [31:0]    rdat_q, rdat_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           cyc_q, cyc_d;
    logic           we_q, we_d;
    logic           tx_wr_q, tx_wr_d;
    logic [7:0]     tx_data_q, tx_data_d;

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        tmo_d     = tmo_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_stb && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)) begin
                    is_wr_d = (bus.rx_data == CMD_WR);
                    cnt_d   = 2'd0;
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (bus.rx_stb) begin
                    addr_d = {addr_q[23:0], bus.rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_BUS;
                            cyc_d   = 1'b1;
                            we_d    = 1'b0;
                            tmo_d   = '0;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (bus.rx_stb) begin
                    wdat_d = {wdat_q[23:0], bus.rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end

            ST_BUS: begin
                // An ack arriving on the final timeout cycle still completes normally.
                if (bus.wb_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = ST_RESP;
                    if (!is_wr_q) begin
                        rdat_d = bus.wb_dat_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_RESP: begin
                // Skipping the cycle after a pulse hides the UART's busy-flag latency.
                if (!bus.tx_busy && !tx_wr_q) begin
                    tx_wr_d = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    if (err_q) begin
                        tx_data_d = C_RSP_ERR;
                    end else if (is_wr_q) begin
                        tx_data_d = C_RSP_OK;
                    end else begin
                        tx_data_d = word_byte(rdat_q, cnt_q);
                    end
                    if (err_q || is_wr_q || cnt_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 2'd0;
            addr_q    <= 32'd0;
            wdat_q    <= 32'd0;
            rdat_q    <= 32'd0;
            tmo_q     <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            tmo_q     <= tmo_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.wb_adr_o = addr_q;
    assign bus.wb_dat_o = wdat_q;
    assign bus.wb_sel_o = 4'hF;
    assign bus.wb_we_o  = we_q;
    assign bus.wb_cyc_o = cyc_q;
    assign bus.wb_stb_o = cyc_q;
    assign bus.tx_wr    = tx_wr_q;
    assign bus.tx_data  = tx_data_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire
